// File: rtl/mem_pkg.sv
// Shared types and widths for the DataRAM arbiter slice.
package mem_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side handshake bus: per-requester request fields in, Done/RespData out.
interface data_mem_arbiter_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]             Req;
    logic [NUM_REQ-1:0]             Wr;
    logic [NUM_REQ-1:0][ADDR_W-1:0] ReqAddr;
    logic [NUM_REQ-1:0][DATA_W-1:0] ReqData;
    logic [NUM_REQ-1:0]             Done;
    logic [DATA_W-1:0]              RespData;

    modport master (
        output Req, Wr, ReqAddr, ReqData,
        input  Done, RespData
    );

    modport slave (
        input  Req, Wr, ReqAddr, ReqData,
        output Done, RespData
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] Req,
    input  logic       LastGnt,
    output logic       Valid,
    output logic       Winner
);

    always_comb begin
        Valid  = |Req;
        Winner = (Req == 2'b11) ? ~LastGnt : Req[1];
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer in front of the single-port DataRAM.
// One access per IDLE -> ACCESS -> RESP pass; read data is registered at the end of ACCESS.
module data_mem_arbiter #(
    parameter int ADDR_W  = mem_pkg::ADDR_W,
    parameter int DATA_W  = mem_pkg::DATA_W,
    parameter int NUM_REQ = mem_pkg::NUM_REQ
) (
    input  logic               CLK,
    input  logic               Reset_n,
    data_mem_arbiter_if.slave  reqBus,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [ADDR_W-1:0]  Address,
    output logic [DATA_W-1:0]  DataSrc,
    input  logic [DATA_W-1:0]  DataMemOut,
    output logic               Busy
);

    import mem_pkg::*;

    arb_state_t         state;
    arb_state_t         nextState;
    logic               lastGnt;
    logic               winner;
    logic               pickValid;
    logic               pickWinner;
    mem_req_t           latched;
    logic [DATA_W-1:0]  respData;
    logic [NUM_REQ-1:0] doneVec;

    rr_pick2 picker (
        .Req     (reqBus.Req),
        .LastGnt (lastGnt),
        .Valid   (pickValid),
        .Winner  (pickWinner)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            lastGnt  <= 1'b1;
            winner   <= 1'b0;
            latched  <= '0;
            respData <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && pickValid) begin
                winner       <= pickWinner;
                latched.wr   <= reqBus.Wr[pickWinner];
                latched.addr <= reqBus.ReqAddr[pickWinner];
                latched.data <= reqBus.ReqData[pickWinner];
            end
            if (state == ACCESS) begin
                lastGnt <= winner;
                if (!latched.wr) begin
                    respData <= DataMemOut;
                end
            end
        end
    end

    // RAM controls decode from state only, so an async reset clears them immediately.
    always_comb begin
        nextState = state;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        DataSrc   = '0;
        doneVec   = '0;
        case (state)
            IDLE: begin
                if (pickValid) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                nextState = RESP;
                Address   = latched.addr;
                MemWrite  = latched.wr;
                MemRead   = ~latched.wr;
                if (latched.wr) begin
                    DataSrc = latched.data;
                end
            end
            RESP: begin
                nextState       = IDLE;
                doneVec[winner] = 1'b1;
            end
            default: nextState = IDLE;
        endcase
    end

    assign reqBus.Done     = doneVec;
    assign reqBus.RespData = respData;
    assign Busy            = (state != IDLE);

endmodule
